// File: rtl/apb_master_pkg.sv
// apb_master_pkg
// Shared types and default widths for the APB command master.
//   state_e : transfer FSM state (IDLE, SETUP, ACCESS)
//   rsp_t   : response payload held while rsp_valid is high
// Optional feature macro used by the importing files: APB_MASTER_TIMEOUT_EN.
package apb_master_pkg;

  localparam int unsigned DEF_ADDR_W         = 32;
  localparam int unsigned DEF_DATA_W         = 32;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  // rdata is sized to the default data width; the master's DATA_W must not
  // exceed DEF_DATA_W.
  typedef struct packed {
    logic [DEF_DATA_W-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } rsp_t;

endpackage

// File: rtl/apb_timeout_cnt.sv
// apb_timeout_cnt
// Counts ACCESS-phase wait cycles and flags the cycle on which the transfer
// has to be aborted. Only instantiated when APB_MASTER_TIMEOUT_EN is defined.
// Ports:
//   PCLK, PRESETn : clock, asynchronous active-low reset
//   clear         : restart the count (asserted while the master is in SETUP,
//                   so the count starts fresh on entry to ACCESS)
//   inc           : an ACCESS cycle with PREADY=0
//   expired       : this wait cycle is the TIMEOUT_CYCLES-th one
module apb_timeout_cnt #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  // cnt holds the number of wait cycles already seen, so the limit is hit
  // when the current wait cycle would make it TIMEOUT_CYCLES.
  assign expired = inc && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/apb_cmd_master.sv
// apb_cmd_master
// Single-outstanding APB3 master: one command in, one APB transfer out, one
// response back.
// Ports:
//   PCLK, PRESETn        : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  : command handshake; cmd_write, cmd_addr, cmd_wdata
//   rsp_valid/rsp_ready  : response handshake; rsp_rdata, rsp_err, rsp_timeout
//   PSELx, PENABLE, PWRITE, PADDR, PWDATA : registered APB request signals
//   PRDATA, PREADY, PSLVERR               : APB slave return signals
//   dbg_state            : current FSM state for observation
// Optional feature: define APB_MASTER_TIMEOUT_EN to abort ACCESS after
// TIMEOUT_CYCLES wait cycles; otherwise ACCESS waits for PREADY forever.
module apb_cmd_master
  import apb_master_pkg::*;
#(
  parameter int unsigned ADDR_W         = DEF_ADDR_W,
  parameter int unsigned DATA_W         = DEF_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              PSELx,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR,
  output state_e            dbg_state
);

  state_e state;
  rsp_t   rsp_q;
  logic   tmo_fire;

  // Handshakes: a transfer on either stream happens at the PCLK edge where
  // valid && ready are both high. The producer holds valid and its payload
  // stable until that edge; ready may depend combinationally on the other
  // stream (cmd_ready on rsp_ready) but never on its own stream's valid.
  assign cmd_ready = (state == IDLE) && (!rsp_valid || rsp_ready);

  assign rsp_rdata   = rsp_q.rdata[DATA_W-1:0];
  assign rsp_err     = rsp_q.err;
  assign rsp_timeout = rsp_q.timeout;
  assign dbg_state   = state;

`ifdef APB_MASTER_TIMEOUT_EN
  apb_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .clear   (state == SETUP),
    .inc     ((state == ACCESS) && !PREADY),
    .expired (tmo_fire)
  );
`else
  // No abort path in this build; the parameter has no effect.
  assign tmo_fire = (TIMEOUT_CYCLES == 0) & 1'b0;
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      PSELx     <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_q     <= '0;
    end else begin
      // A new response can never load while one is pending (single
      // outstanding), so clearing here cannot collide with the loads below.
      if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            PADDR  <= cmd_addr;
            PWRITE <= cmd_write;
            PWDATA <= cmd_write ? cmd_wdata : '0;
            PSELx  <= 1'b1;
            state  <= SETUP;
          end
        end

        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
        end

        ACCESS: begin
          // PREADY wins over a timeout firing on the same edge.
          if (PREADY) begin
            rsp_q.rdata   <= PWRITE ? '0 : DEF_DATA_W'(PRDATA);
            rsp_q.err     <= PSLVERR;
            rsp_q.timeout <= 1'b0;
            rsp_valid     <= 1'b1;
            PSELx         <= 1'b0;
            PENABLE       <= 1'b0;
            state         <= IDLE;
          end else if (tmo_fire) begin
            rsp_q.rdata   <= '0;
            rsp_q.err     <= 1'b1;
            rsp_q.timeout <= 1'b1;
            rsp_valid     <= 1'b1;
            PSELx         <= 1'b0;
            PENABLE       <= 1'b0;
            state         <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
